// File: rtl/usr_deser_if.sv
// Bundles the serial input, control and word-output handshake of usr_deser.
// The deserializer connects through the slave modport; its driver uses master.
interface usr_deser_if #(
    parameter int WIDTH = 4
);
    logic             ser_in;
    logic             ser_valid;
    logic [1:0]       dir;
    logic             clr;
    logic [WIDTH-1:0] word_o;
    logic             word_valid;
    logic             word_ready;
    logic             overrun;
    logic             parity_err;
    logic             busy;

    modport master (
        output ser_in, ser_valid, dir, clr, word_ready,
        input  word_o, word_valid, overrun, parity_err, busy
    );

    modport slave (
        input  ser_in, ser_valid, dir, clr, word_ready,
        output word_o, word_valid, overrun, parity_err, busy
    );
endinterface

// File: rtl/usr_deser.sv
// Serial-to-parallel receiver with a one-entry valid/ready output register.
// Optional feature macro: PARITY_CHECK_EN (adds a trailing even-parity bit per word).
module usr_deser #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    usr_deser_if.slave  bus
);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_PAR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1} state_t;
`endif

    localparam logic [1:0] DIR_MSB   = 2'b10;
    localparam logic [1:0] DIR_LSB   = 2'b01;
    localparam logic [1:0] DIR_ABORT = 2'b11;

    state_t             state_r, state_nxt_s;
    logic [WIDTH-1:0]   shreg_r, shreg_nxt_s;
    logic [CNT_W-1:0]   bit_cnt_r, bit_cnt_nxt_s;
    logic [1:0]         dir_q_r, dir_q_nxt_s;
    logic [WIDTH-1:0]   word_r;
    logic               word_valid_r;
    logic               overrun_r;
    logic               parity_err_r;
    logic               busy_r;
    logic               bit_ok_s;
    logic               complete_s;
    logic [WIDTH-1:0]   done_word_s;
    logic               perr_s;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s,
                                                  input logic [1:0] d,
                                                  input logic b);
        logic [WIDTH-1:0] r;
        if (d == DIR_MSB) begin
            r = {s[WIDTH-2:0], b};
        end else begin
            r = {b, s[WIDTH-1:1]};
        end
        return r;
    endfunction

`ifdef PARITY_CHECK_EN
    function automatic logic even_par(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    assign bit_ok_s = bus.ser_valid && ((bus.dir == DIR_MSB) || (bus.dir == DIR_LSB));

    // Next-state logic: bit acceptance, abort, clear and word completion
    always_comb begin
        state_nxt_s   = state_r;
        shreg_nxt_s   = shreg_r;
        bit_cnt_nxt_s = bit_cnt_r;
        dir_q_nxt_s   = dir_q_r;
        complete_s    = 1'b0;
        done_word_s   = shreg_r;
        perr_s        = 1'b0;
        if (bus.clr) begin
            state_nxt_s   = ST_IDLE;
            shreg_nxt_s   = {WIDTH{1'b0}};
            bit_cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bit_ok_s) begin
                        shreg_nxt_s   = shift_in(shreg_r, bus.dir, bus.ser_in);
                        dir_q_nxt_s   = bus.dir;
                        bit_cnt_nxt_s = CNT_W'(1);
                        state_nxt_s   = ST_SHIFT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (bus.dir == DIR_ABORT) begin
                        shreg_nxt_s   = {WIDTH{1'b0}};
                        bit_cnt_nxt_s = {CNT_W{1'b0}};
                        state_nxt_s   = ST_IDLE;
                    end else if (bit_ok_s) begin
                        shreg_nxt_s = shift_in(shreg_r, dir_q_r, bus.ser_in);
                        if (bit_cnt_r == CNT_W'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
                            bit_cnt_nxt_s = CNT_W'(WIDTH);
                            state_nxt_s   = ST_PAR;
`else
                            complete_s    = 1'b1;
                            done_word_s   = shift_in(shreg_r, dir_q_r, bus.ser_in);
                            bit_cnt_nxt_s = {CNT_W{1'b0}};
                            state_nxt_s   = ST_IDLE;
`endif
                        end else begin
                            bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
                        end
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end
`ifdef PARITY_CHECK_EN
                ST_PAR: begin
                    if (bus.dir == DIR_ABORT) begin
                        shreg_nxt_s   = {WIDTH{1'b0}};
                        bit_cnt_nxt_s = {CNT_W{1'b0}};
                        state_nxt_s   = ST_IDLE;
                    end else if (bit_ok_s) begin
                        complete_s    = 1'b1;
                        done_word_s   = shreg_r;
                        perr_s        = even_par(shreg_r) ^ bus.ser_in;
                        bit_cnt_nxt_s = {CNT_W{1'b0}};
                        state_nxt_s   = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_PAR;
                    end
                end
`endif
                default: begin
                    state_nxt_s   = ST_IDLE;
                    shreg_nxt_s   = {WIDTH{1'b0}};
                    bit_cnt_nxt_s = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State, shift register and one-entry output register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r      <= ST_IDLE;
            shreg_r      <= {WIDTH{1'b0}};
            bit_cnt_r    <= {CNT_W{1'b0}};
            dir_q_r      <= 2'b00;
            word_r       <= {WIDTH{1'b0}};
            word_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
            parity_err_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            shreg_r   <= shreg_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            dir_q_r   <= dir_q_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
            // A pending word that is being consumed frees the slot for a new one
            if (complete_s) begin
                if (!word_valid_r || bus.word_ready) begin
                    word_r       <= done_word_s;
                    word_valid_r <= 1'b1;
                    parity_err_r <= perr_s;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (word_valid_r && bus.word_ready) begin
                word_valid_r <= 1'b0;
            end else begin
                word_valid_r <= word_valid_r;
            end
            if (bus.clr) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign bus.word_o     = word_r;
    assign bus.word_valid = word_valid_r;
    assign bus.overrun    = overrun_r;
    assign bus.parity_err = parity_err_r;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_usr_deser.sv
// Self-checking bench for usr_deser: directed scenarios plus random traffic
// compared cycle by cycle against a bit-list reference model.
module tb_usr_deser;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    usr_deser_if #(.WIDTH(W)) bus ();

    usr_deser #(.WIDTH(W), .CNT_W(3)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // reference model state
    int   m_bits[$];
    int   m_dir;
    bit   m_active;
    bit   m_inpar;
    int   m_word;
    bit   m_valid;
    bit   m_ovr;
    bit   m_perr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int word_of(input int bits[$], input int d);
        int w = 0;
        for (int i = 0; i < W; i++) begin
            if (d == 2) w = w + (bits[i] << (W - 1 - i));
            else        w = w + (bits[i] << i);
        end
        return w;
    endfunction

    task automatic model_step(input bit r, input bit c, input bit sv, input bit sin,
                              input int d, input bit rdy);
        bit complete = 1'b0;
        int cw = 0;
        bit cp = 1'b0;
        bit good = sv && (d == 2 || d == 1);
        if (r) begin
            m_bits.delete(); m_active = 0; m_inpar = 0;
            m_word = 0; m_valid = 0; m_ovr = 0; m_perr = 0;
            return;
        end
        if (c) begin
            m_bits.delete(); m_active = 0; m_inpar = 0; m_ovr = 0;
        end else if (!m_active) begin
            if (good) begin
                m_bits.delete(); m_bits.push_back(int'(sin)); m_dir = d; m_active = 1;
            end
        end else if (d == 3) begin
            m_bits.delete(); m_active = 0; m_inpar = 0;
        end else if (good) begin
            if (m_inpar) begin
                complete = 1; cw = word_of(m_bits, m_dir);
                cp = (^cw[W-1:0]) ^ sin;
                m_active = 0; m_inpar = 0;
            end else begin
                m_bits.push_back(int'(sin));
                if (m_bits.size() == W) begin
`ifdef PARITY_CHECK_EN
                    m_inpar = 1;
`else
                    complete = 1; cw = word_of(m_bits, m_dir); m_active = 0;
`endif
                end
            end
        end
        if (complete) begin
            if (!m_valid || rdy) begin
                m_word = cw; m_valid = 1; m_perr = cp;
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    task automatic cyc(input bit r, input bit c, input bit sv, input bit sin,
                       input logic [1:0] d, input bit rdy);
        rst = r; bus.clr = c; bus.ser_valid = sv; bus.ser_in = sin;
        bus.dir = d; bus.word_ready = rdy;
        model_step(r, c, sv, sin, int'(d), rdy);
        @(posedge clk);
        #1;
        check("word_o",     32'(bus.word_o),     32'(m_word));
        check("word_valid", 32'(bus.word_valid), 32'(m_valid));
        check("overrun",    32'(bus.overrun),    32'(m_ovr));
        check("parity_err", 32'(bus.parity_err), 32'(m_perr));
        check("busy",       32'(bus.busy),       32'(m_active));
    endtask

    task automatic send(input logic [W-1:0] w, input logic [1:0] d, input bit rdy);
        for (int i = 0; i < W; i++)
            cyc(1'b0, 1'b0, 1'b1, (d == 2'b10) ? w[W-1-i] : w[i], d, rdy);
    endtask

    initial begin
        logic [W-1:0] v;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        check("reset_valid", 32'(bus.word_valid), 32'd0);
        check("reset_word",  32'(bus.word_o), 32'd0);

        // 1: MSB-first 1,0,1,1
        send(4'hB, 2'b10, 1'b1);
        check("t1_word", 32'(bus.word_o), 32'hB);
        check("t1_valid", 32'(bus.word_valid), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        check("t1_drop", 32'(bus.word_valid), 32'd0);

        // 2: LSB-first 1,0,1,1 with dir changing mid-word
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1);
        check("t2_word", 32'(bus.word_o), 32'hD);

        // 3: overrun with stalled consumer, then clr
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        send(4'hA, 2'b10, 1'b0);
        send(4'h5, 2'b10, 1'b0);
        check("t3_word", 32'(bus.word_o), 32'hA);
        check("t3_ovr", 32'(bus.overrun), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        check("t3_clr_ovr", 32'(bus.overrun), 32'd0);
        check("t3_clr_valid", 32'(bus.word_valid), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);

        // 4: abort after two bits
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1);
        send(4'h6, 2'b10, 1'b1);
        check("t4_word", 32'(bus.word_o), 32'h6);

        // 5: completion coinciding with consumption
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        send(4'hA, 2'b10, 1'b0);
        for (int i = 0; i < W - 1; i++)
            cyc(1'b0, 1'b0, 1'b1, (i == 1), 2'b10, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1);
        check("t5_word", 32'(bus.word_o), 32'h5);
        check("t5_valid", 32'(bus.word_valid), 32'd1);
        check("t5_ovr", 32'(bus.overrun), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        check("t5_rst_busy", 32'(bus.busy), 32'd0);
        check("t5_rst_word", 32'(bus.word_o), 32'd0);
        send(4'hC, 2'b10, 1'b1);
        check("t5_clean", 32'(bus.word_o), 32'hC);

`ifdef PARITY_CHECK_EN
        // 6: parity good then bad
        send(4'hB, 2'b10, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1);
        check("t6_perr_ok", 32'(bus.parity_err), 32'd0);
        send(4'hB, 2'b10, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1);
        check("t6_perr_bad", 32'(bus.parity_err), 32'd1);
`else
        // 6: a fifth bit starts the next word
        send(4'hB, 2'b10, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1);
        check("t6_new_word", 32'(bus.busy), 32'd1);
        check("t6_perr", 32'(bus.parity_err), 32'd0);
`endif

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] d;
            bit sv, r, c;
            int pick = $urandom_range(0, 19);
            d  = (pick < 8) ? 2'b10 : (pick < 16) ? 2'b01 : (pick < 19) ? 2'b00 : 2'b11;
            sv = ($urandom_range(0, 3) != 0) || (d == 2'b11);
            r  = ($urandom_range(0, 299) == 0);
            c  = ($urandom_range(0, 59) == 0);
            v  = W'($urandom);
            cyc(r, c, sv, v[0], d, $urandom_range(0, 2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
